// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory. CPU and DMA ports use req/ack,
// one access is in flight at a time, and the memory read latency is absorbed in WAIT.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          cclk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    grant
);

    // state  | meaning
    // IDLE   | sample requests, pick a winner
    // ISSUE  | drive the memory strobe for one cycle
    // WAIT   | count down the read latency, capture read data at terminal count
    // DONE   | one-cycle ack to the owner
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_dma_q, last_dma_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic pick_dma, pick_cpu;

    // With both requesting, the side that did not win last time goes next.
    assign pick_dma = dma_req & (~cpu_req | ~last_dma_q);
    assign pick_cpu = cpu_req & ~pick_dma;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_dma_d = last_dma_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (pick_cpu) begin
                    grant_d    = 2'b01;
                    last_dma_d = 1'b0;
                    we_d       = cpu_we;
                    addr_d     = cpu_addr;
                    wdata_d    = cpu_wdata;
                    state_d    = S_ISSUE;
                end else if (pick_dma) begin
                    grant_d    = 2'b10;
                    last_dma_d = 1'b1;
                    we_d       = dma_we;
                    addr_d     = dma_addr;
                    wdata_d    = dma_wdata;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = LAT_M1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = mem_rdata;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= 2'b00;
            last_dma_q <= 1'b1;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_dma_q <= last_dma_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    assign mem_en    = (state_q == S_ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = (state_q == S_DONE) & grant_q[0];
    assign dma_ack   = (state_q == S_DONE) & grant_q[1];
    assign busy      = (state_q != S_IDLE);
    assign grant     = grant_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=4,
// each fed by a read-only memory model that returns data only in the valid cycle.
module tb_mem_arbiter;

    localparam logic [31:0] JUNK = 32'h0BAD0BAD;

    logic        cclk;
    int          n_checks = 0;
    int          n_fail   = 0;

    // MEM_LAT=1 instance
    logic        rst, cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_ack, dma_ack, mem_en, mem_we, busy;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant;

    // MEM_LAT=4 instance
    logic        rst_4, cpu_req_4, cpu_we_4, dma_req_4, dma_we_4;
    logic [31:0] cpu_addr_4, cpu_wdata_4, dma_addr_4, dma_wdata_4;
    logic        cpu_ack_4, dma_ack_4, mem_en_4, mem_we_4, busy_4;
    logic [31:0] rdata_4, mem_addr_4, mem_wdata_4, mem_rdata_4;
    logic [1:0]  grant_4;

    logic [31:0] model_mem [0:255];

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut (
        .cclk(cclk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) u_dut4 (
        .cclk(cclk), .rst(rst_4),
        .cpu_req(cpu_req_4), .cpu_we(cpu_we_4), .cpu_addr(cpu_addr_4), .cpu_wdata(cpu_wdata_4), .cpu_ack(cpu_ack_4),
        .dma_req(dma_req_4), .dma_we(dma_we_4), .dma_addr(dma_addr_4), .dma_wdata(dma_wdata_4), .dma_ack(dma_ack_4),
        .rdata(rdata_4), .mem_en(mem_en_4), .mem_we(mem_we_4), .mem_addr(mem_addr_4), .mem_wdata(mem_wdata_4),
        .mem_rdata(mem_rdata_4), .busy(busy_4), .grant(grant_4)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    // Read data is only valid exactly MEM_LAT cycles after the strobe; otherwise junk.
    bit          p1_v;
    logic [31:0] p1_d;
    bit          p4_v [0:3];
    logic [31:0] p4_d [0:3];

    always @(posedge cclk) begin
        p1_v <= mem_en & ~mem_we;
        p1_d <= model_mem[mem_addr[9:2]];
        p4_v[0] <= mem_en_4 & ~mem_we_4;
        p4_d[0] <= model_mem[mem_addr_4[9:2]];
        for (int k = 1; k < 4; k++) begin
            p4_v[k] <= p4_v[k-1];
            p4_d[k] <= p4_d[k-1];
        end
    end

    assign mem_rdata   = p1_v ? p1_d : JUNK;
    assign mem_rdata_4 = p4_v[3] ? p4_d[3] : JUNK;

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        rst_4 = 1'b1; cpu_req_4 = 0; cpu_we_4 = 0; cpu_addr_4 = 0; cpu_wdata_4 = 0;
        dma_req_4 = 0; dma_we_4 = 0; dma_addr_4 = 0; dma_wdata_4 = 0;
        tick();
        tick();
        rst = 1'b0;
        rst_4 = 1'b0;
        n_checks++;
        if ({cpu_ack, dma_ack, mem_en, mem_we, busy, grant} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, expected 0000000", {cpu_ack, dma_ack, mem_en, mem_we, busy, grant});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, rdata} !== 96'b0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, expected all 0", mem_addr, mem_wdata, rdata);
        end
        n_checks++;
        if ({cpu_ack_4, dma_ack_4, mem_en_4, mem_we_4, busy_4, grant_4, rdata_4} !== 39'b0) begin
            n_fail++;
            $display("FAIL reset_lat4: got ctrl=%b rdata=%h, expected 0", {cpu_ack_4, dma_ack_4, mem_en_4, mem_we_4, busy_4, grant_4}, rdata_4);
        end
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        tick();
        n_checks++;
        if ({mem_en, mem_we, busy, grant} !== 5'b10101 || mem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL cpu_read_issue: got en/we/busy/grant=%b addr=%h, expected 10101 addr=00000040", {mem_en, mem_we, busy, grant}, mem_addr);
        end
        tick();
        n_checks++;
        if (mem_en !== 1'b0 || cpu_ack !== 1'b0 || mem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL cpu_read_wait: got en=%b ack=%b addr=%h, expected en=0 ack=0 addr=00000040", mem_en, cpu_ack, mem_addr);
        end
        tick();
        n_checks++;
        if ({cpu_ack, dma_ack, grant} !== 4'b1001 || rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL cpu_read_ack: got acks/grant=%b rdata=%h, expected 1001 rdata=deadbeef", {cpu_ack, dma_ack, grant}, rdata);
        end
        cpu_req = 0;
        tick();
        n_checks++;
        if ({cpu_ack, busy, grant} !== 4'b0) begin
            n_fail++;
            $display("FAIL cpu_read_idle: got ack/busy/grant=%b, expected 0000", {cpu_ack, busy, grant});
        end
    endtask

    task automatic test_dma_write();
        dma_req = 1; dma_we = 1; dma_addr = 32'h100; dma_wdata = 32'h12345678;
        tick();
        n_checks++;
        if ({mem_en, mem_we, grant} !== 4'b1110 || mem_addr !== 32'h100 || mem_wdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL dma_write_issue: got en/we/grant=%b addr=%h wdata=%h, expected 1110 00000100 12345678", {mem_en, mem_we, grant}, mem_addr, mem_wdata);
        end
        tick();
        n_checks++;
        if ({dma_ack, cpu_ack, mem_en} !== 3'b100 || rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL dma_write_ack: got dack/cack/en=%b rdata=%h, expected 100 rdata=deadbeef", {dma_ack, cpu_ack, mem_en}, rdata);
        end
        dma_req = 0; dma_we = 0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] order [0:3];
        int n_iss = 0;
        int n_ack = 0;
        bit overlap = 0;
        rst = 1; tick(); rst = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        dma_req = 1; dma_we = 0; dma_addr = 32'h80;
        for (int c = 0; c < 40 && n_ack < 4; c++) begin
            tick();
            if (mem_en && n_iss < 4) begin
                order[n_iss] = grant;
                n_iss++;
            end
            if (cpu_ack && dma_ack) overlap = 1;
            if (cpu_ack || dma_ack) begin
                n_ack++;
                n_checks++;
                if (rdata !== (dma_ack ? 32'hCAFEF00D : 32'hDEADBEEF)) begin
                    n_fail++;
                    $display("FAIL rr_rdata%0d: got %h, expected %h", n_ack, rdata, dma_ack ? 32'hCAFEF00D : 32'hDEADBEEF);
                end
                if (n_ack == 4) begin
                    cpu_req = 0;
                    dma_req = 0;
                end
            end
        end
        cpu_req = 0; dma_req = 0;
        n_checks++;
        if (n_ack != 4 || n_iss != 4) begin
            n_fail++;
            $display("FAIL rr_count: got %0d acks %0d issues, expected 4 and 4", n_ack, n_iss);
        end else begin
            n_checks++;
            if ({order[0], order[1], order[2], order[3]} !== 8'b01100110) begin
                n_fail++;
                $display("FAIL rr_order: got %b, expected 01100110", {order[0], order[1], order[2], order[3]});
            end
        end
        n_checks++;
        if (overlap) begin
            n_fail++;
            $display("FAIL rr_ack_overlap: got overlap=1, expected 0");
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_idle: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h200; cpu_wdata = 32'hA5A5A5A5;
        tick();
        tick();
        n_checks++;
        if (cpu_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ack1: got %b, expected 1", cpu_ack);
        end
        cpu_addr = 32'h204; cpu_wdata = 32'h5A5A5A5A;
        tick();
        n_checks++;
        if ({busy, mem_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_gap: got busy/en=%b, expected 00", {busy, mem_en});
        end
        tick();
        n_checks++;
        if ({mem_en, mem_we, grant} !== 4'b1101 || mem_addr !== 32'h204 || mem_wdata !== 32'h5A5A5A5A) begin
            n_fail++;
            $display("FAIL b2b_issue2: got en/we/grant=%b addr=%h wdata=%h, expected 1101 00000204 5a5a5a5a", {mem_en, mem_we, grant}, mem_addr, mem_wdata);
        end
        tick();
        n_checks++;
        if (cpu_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ack2: got %b, expected 1", cpu_ack);
        end
        cpu_req = 0; cpu_we = 0;
        tick();
    endtask

    task automatic test_mid_request();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        tick();
        tick();
        dma_req = 1; dma_we = 0; dma_addr = 32'h80;
        tick();
        n_checks++;
        if ({cpu_ack, dma_ack, grant} !== 4'b1001) begin
            n_fail++;
            $display("FAIL mid_cpu_ack: got acks/grant=%b, expected 1001", {cpu_ack, dma_ack, grant});
        end
        cpu_req = 0;
        tick();
        n_checks++;
        if ({busy, mem_en, grant} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_idle: got busy/en/grant=%b, expected 0000", {busy, mem_en, grant});
        end
        tick();
        n_checks++;
        if ({mem_en, grant} !== 3'b110 || mem_addr !== 32'h80) begin
            n_fail++;
            $display("FAIL mid_dma_issue: got en/grant=%b addr=%h, expected 110 00000080", {mem_en, grant}, mem_addr);
        end
        tick();
        tick();
        n_checks++;
        if ({dma_ack, cpu_ack} !== 2'b10 || rdata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL mid_dma_ack: got dack/cack=%b rdata=%h, expected 10 cafef00d", {dma_ack, cpu_ack}, rdata);
        end
        dma_req = 0;
        tick();
    endtask

    task automatic test_lat4();
        cpu_req_4 = 1; cpu_we_4 = 0; cpu_addr_4 = 32'h44;
        for (int c = 1; c <= 7; c++) begin
            tick();
            n_checks++;
            if ({busy_4, mem_en_4, cpu_ack_4} !== {(c <= 6), (c == 1), (c == 6)}) begin
                n_fail++;
                $display("FAIL lat4_cycle%0d: got busy/en/ack=%b, expected %b", c, {busy_4, mem_en_4, cpu_ack_4}, {(c <= 6), (c == 1), (c == 6)});
            end
            if (c == 6) begin
                n_checks++;
                if (rdata_4 !== 32'h0A0B0C0D) begin
                    n_fail++;
                    $display("FAIL lat4_rdata: got %h, expected 0a0b0c0d", rdata_4);
                end
                cpu_req_4 = 0;
            end
        end
    endtask

    task automatic test_reset_mid();
        cpu_req_4 = 1; cpu_we_4 = 0; cpu_addr_4 = 32'h48;
        tick();
        tick();
        rst_4 = 1;
        tick();
        rst_4 = 0;
        n_checks++;
        if ({cpu_ack_4, dma_ack_4, mem_en_4, mem_we_4, busy_4, grant_4} !== 7'b0 || rdata_4 !== 32'h0 || mem_addr_4 !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got ctrl=%b rdata=%h addr=%h, expected all 0", {cpu_ack_4, dma_ack_4, mem_en_4, mem_we_4, busy_4, grant_4}, rdata_4, mem_addr_4);
        end
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_checks++;
            if (cpu_ack_4 !== (c == 6)) begin
                n_fail++;
                $display("FAIL rstmid_ack_cycle%0d: got %b, expected %b", c, cpu_ack_4, (c == 6));
            end
        end
        n_checks++;
        if (rdata_4 !== 32'h11223344) begin
            n_fail++;
            $display("FAIL rstmid_rdata: got %h, expected 11223344", rdata_4);
        end
        cpu_req_4 = 0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        model_mem[16] = 32'hDEADBEEF;
        model_mem[17] = 32'h0A0B0C0D;
        model_mem[18] = 32'h11223344;
        model_mem[32] = 32'hCAFEF00D;
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_round_robin();
        test_back_to_back();
        test_mid_request();
        test_lat4();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory between two requesters: the multicycle CPU memory port (requester 0, fetch/load/store traffic) and a DMA/program-loader port (requester 1).
- Each requester uses a req/ack handshake. The arbiter sequences one memory access at a time and absorbs the memory read latency.
- Sits between the CPU datapath memory interface and the memory macro. The CPU control FSM holds its state until `cpu_ack`.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, memory read latency in cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1..15.

Ports:
- cclk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- cpu_req  input  1  CPU request; held high until `cpu_ack`.
- cpu_we  input  1  1 = write, 0 = read; stable while `cpu_req` is high.
- cpu_addr  input  AW  CPU address; stable while `cpu_req` is high.
- cpu_wdata  input  DW  CPU write data.
- cpu_ack  output  1  one-cycle completion pulse to the CPU.
- dma_req  input  1  DMA request; same rules as `cpu_req`.
- dma_we  input  1  DMA write enable.
- dma_addr  input  AW  DMA address.
- dma_wdata  input  DW  DMA write data.
- dma_ack  output  1  one-cycle completion pulse to the DMA.
- rdata  output  DW  registered read data; valid in the ack cycle, held until the next read capture.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid MEM_LAT cycles after the `mem_en` cycle.
- busy  output  1  high in every state except IDLE.
- grant  output  2  one-hot owner of the current transaction: bit0 = CPU, bit1 = DMA; 00 in IDLE.

Behaviour:
- Clocking and reset: clock is `cclk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, grant=00, last_grant=DMA, cnt=0, rdata=0. All outputs are 0: acks, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`.
- Reset mid-transaction: the transaction is abandoned with no ack, and `mem_en` is low from the next cycle. The requester re-issues.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample both requests.
  - Only one request high: that requester is granted.
  - Both high: round-robin; the requester not in last_grant wins.
  - None high: stay in IDLE.
  - On a grant: register grant and the winner's we/addr/wdata, update last_grant, go to ISSUE.
- ISSUE (1 cycle):
  - `mem_en`=1, `mem_we`=latched we, `mem_addr`/`mem_wdata` = latched values.
  - Write: go to DONE.
  - Read: cnt=MEM_LAT-1, go to WAIT.
- WAIT:
  - `mem_en`=0, `mem_addr` held.
  - cnt≠0: cnt decrements.
  - cnt==0: capture `mem_rdata` into `rdata`, go to DONE.
- DONE (1 cycle): the granted requester's ack=1, then go to IDLE. `rdata` is unchanged for writes.
- Latency, counted from the IDLE sampling edge (cycle 0):
  - Write: ISSUE at cycle 1, ack at cycle 2.
  - Read: ack at cycle MEM_LAT+2.
  - Minimum request-to-request spacing per transaction is 3 cycles for a write and MEM_LAT+3 for a read.
- Handshake rules:
  - The requester deasserts req in the cycle after ack; IDLE then sees it low.
  - A req still high in the cycle after ack is treated as a new request.
  - Requests arriving while `busy` is high wait; they are not dropped.
  - `cpu_ack` and `dma_ack` are never high together.
  - An ack is never issued to a requester whose req was low at the grant.
- Starvation bound: with both requesting continuously, grants strictly alternate, so each requester waits at most one foreign transaction.
- Width rules: cnt is 4 bits. No address or data arithmetic; pure muxing and registering.

Test Plan:
- Reset then single CPU read, MEM_LAT=1: `cpu_req`=1, `cpu_addr`=0x40, `mem_rdata`=0xDEADBEEF one cycle after `mem_en` → `mem_en` for exactly 1 cycle with addr 0x40, `cpu_ack` at cycle 3, `rdata`=0xDEADBEEF, `grant`=01.
- DMA write: `dma_req`=1, `dma_we`=1, addr 0x100, wdata 0x12345678 → `mem_en`=`mem_we`=1 at cycle 1 with those values, `dma_ack` at cycle 2, `rdata` unchanged.
- Simultaneous requests held high for 4 transactions (reads) → grant order after reset is CPU, DMA, CPU, DMA; acks never overlap.
- MEM_LAT=4 read → WAIT lasts 4 cycles, ack at cycle 6, `busy` high for cycles 1-6.
- Reset asserted during WAIT → next cycle all outputs 0, no ack emitted, state IDLE. A subsequent request completes normally.
- Request arrives mid-transaction: `dma_req` rises while the CPU read is in WAIT → DMA granted on the first IDLE cycle after `cpu_ack`, not earlier.
